md5: RTL and testbench

// - Single-block MD5 hash engine: hashes one message of 0..55 bytes supplied in one 512-bit word.
// - Pads internally (RFC 1321), runs 64 rounds at one round per clock, returns the 128-bit digest.
// - Standalone accelerator; short-message hashing only, no multi-block chaining.

---
 rtl/md5.sv | 182 ++++++++++++++++++
 tb/tb_md5.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/md5.sv
// Single-block MD5 engine: internal RFC 1321 padding, one round per clock, 128-bit digest.
// Optional MD5_LEN_ERR_EN adds a len_err flag for saturated or non-byte-aligned lengths.
`timescale 1ns/1ps
module md5 (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_in_ready,
  input  logic [8:0]   data_in_length,
  input  logic [511:0] data_in,
  output logic [127:0] hash,
  output logic         hash_ready
`ifdef MD5_LEN_ERR_EN
  ,
  output logic         len_err
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] a, b, c, d;
  logic [31:0] m [16];

  logic [5:0]  nbytes;
  logic [31:0] nb;
  logic [63:0] bitlen;
  logic [7:0]  pad [64];
  logic [31:0] pad_m [16];

  logic [31:0] f, k_cur, tmp, rot, b_nxt;
  logic [63:0] rot_dbl;
  logic [3:0]  g;
  logic [4:0]  s;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] i);
    logic [31:0] k;
    k = '0;
    case (i)
      6'd0:  k = 32'hd76aa478; 6'd1:  k = 32'he8c7b756; 6'd2:  k = 32'h242070db; 6'd3:  k = 32'hc1bdceee;
      6'd4:  k = 32'hf57c0faf; 6'd5:  k = 32'h4787c62a; 6'd6:  k = 32'ha8304613; 6'd7:  k = 32'hfd469501;
      6'd8:  k = 32'h698098d8; 6'd9:  k = 32'h8b44f7af; 6'd10: k = 32'hffff5bb1; 6'd11: k = 32'h895cd7be;
      6'd12: k = 32'h6b901122; 6'd13: k = 32'hfd987193; 6'd14: k = 32'ha679438e; 6'd15: k = 32'h49b40821;
      6'd16: k = 32'hf61e2562; 6'd17: k = 32'hc040b340; 6'd18: k = 32'h265e5a51; 6'd19: k = 32'he9b6c7aa;
      6'd20: k = 32'hd62f105d; 6'd21: k = 32'h02441453; 6'd22: k = 32'hd8a1e681; 6'd23: k = 32'he7d3fbc8;
      6'd24: k = 32'h21e1cde6; 6'd25: k = 32'hc33707d6; 6'd26: k = 32'hf4d50d87; 6'd27: k = 32'h455a14ed;
      6'd28: k = 32'ha9e3e905; 6'd29: k = 32'hfcefa3f8; 6'd30: k = 32'h676f02d9; 6'd31: k = 32'h8d2a4c8a;
      6'd32: k = 32'hfffa3942; 6'd33: k = 32'h8771f681; 6'd34: k = 32'h6d9d6122; 6'd35: k = 32'hfde5380c;
      6'd36: k = 32'ha4beea44; 6'd37: k = 32'h4bdecfa9; 6'd38: k = 32'hf6bb4b60; 6'd39: k = 32'hbebfbc70;
      6'd40: k = 32'h289b7ec6; 6'd41: k = 32'heaa127fa; 6'd42: k = 32'hd4ef3085; 6'd43: k = 32'h04881d05;
      6'd44: k = 32'hd9d4d039; 6'd45: k = 32'he6db99e5; 6'd46: k = 32'h1fa27cf8; 6'd47: k = 32'hc4ac5665;
      6'd48: k = 32'hf4292244; 6'd49: k = 32'h432aff97; 6'd50: k = 32'hab9423a7; 6'd51: k = 32'hfc93a039;
      6'd52: k = 32'h655b59c3; 6'd53: k = 32'h8f0ccc92; 6'd54: k = 32'hffeff47d; 6'd55: k = 32'h85845dd1;
      6'd56: k = 32'h6fa87e4f; 6'd57: k = 32'hfe2ce6e0; 6'd58: k = 32'ha3014314; 6'd59: k = 32'h4e0811a1;
      6'd60: k = 32'hf7537e82; 6'd61: k = 32'hbd3af235; 6'd62: k = 32'h2ad7d2bb; 6'd63: k = 32'heb86d391;
      default: k = '0;
    endcase
    return k;
  endfunction

  // Padded block: whole bytes only, saturated at 55 so the 0x80 marker and length always fit.
  always_comb begin
    nbytes = (data_in_length[8:3] > 6'd55) ? 6'd55 : data_in_length[8:3];
    nb     = {26'd0, nbytes};
    bitlen = {55'd0, nbytes, 3'd0};
    for (int unsigned k = 0; k < 64; k++) begin
      if (k < nb)
        pad[k] = data_in[511 - 8*k -: 8];
      else if (k == nb)
        pad[k] = 8'h80;
      else if (k >= 56)
        pad[k] = bitlen[8*(k-56) +: 8];
      else
        pad[k] = '0;
    end
    for (int unsigned i = 0; i < 16; i++)
      pad_m[i] = {pad[4*i+3], pad[4*i+2], pad[4*i+1], pad[4*i]};
  end

  always_comb begin
    f = '0;
    g = '0;
    case (cnt[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = cnt[3:0];                end
      2'd1: begin f = (d & b) | (~d & c); g = cnt[3:0] * 4'd5 + 4'd1;  end
      2'd2: begin f = b ^ c ^ d;          g = cnt[3:0] * 4'd3 + 4'd5;  end
      default: begin f = c ^ (b | ~d);    g = cnt[3:0] * 4'd7;         end
    endcase
    case ({cnt[5:4], cnt[1:0]})
      4'h0: s = 5'd7;  4'h1: s = 5'd12; 4'h2: s = 5'd17; 4'h3: s = 5'd22;
      4'h4: s = 5'd5;  4'h5: s = 5'd9;  4'h6: s = 5'd14; 4'h7: s = 5'd20;
      4'h8: s = 5'd4;  4'h9: s = 5'd11; 4'ha: s = 5'd16; 4'hb: s = 5'd23;
      4'hc: s = 5'd6;  4'hd: s = 5'd10; 4'he: s = 5'd15; default: s = 5'd21;
    endcase
    k_cur   = k_rom(cnt);
    tmp     = a + f + k_cur + m[g];
    rot_dbl = {tmp, tmp} << s;
    rot     = rot_dbl[63:32];
    b_nxt   = b + rot;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_in_ready)                state_nxt = ROUND;
      ROUND:   if (cnt == 6'd63)                 state_nxt = DONE;
      DONE:    if (hash_ready && !data_in_ready) state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // The final IV add lands with step 63; the digest register loads on the first DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      hash       <= '0;
      hash_ready <= 1'b0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      for (int unsigned i = 0; i < 16; i++) m[i] <= '0;
`ifdef MD5_LEN_ERR_EN
      len_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_in_ready) begin
            for (int unsigned i = 0; i < 16; i++) m[i] <= pad_m[i];
            a   <= IV_A;
            b   <= IV_B;
            c   <= IV_C;
            d   <= IV_D;
            cnt <= '0;
`ifdef MD5_LEN_ERR_EN
            len_err <= (data_in_length > 9'd440) || (data_in_length[2:0] != 3'd0);
`endif
          end
        end
        ROUND: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            a <= d + IV_A;
            b <= b_nxt + IV_B;
            c <= b + IV_C;
            d <= c + IV_D;
          end else begin
            a <= d;
            b <= b_nxt;
            c <= b;
            d <= c;
          end
        end
        DONE: begin
          if (!hash_ready) begin
            hash       <= {bswap(a), bswap(b), bswap(c), bswap(d)};
            hash_ready <= 1'b1;
          end else if (!data_in_ready) begin
            hash_ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5.sv
// Directed and randomized bench for md5, checked against a behavioural MD5 model
// whose round constants are derived from sin() rather than a table.
`timescale 1ns/1ps
module tb_md5;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_in_ready;
  logic [8:0]   data_in_length;
  logic [511:0] data_in;
  logic [127:0] hash;
  logic         hash_ready;

  int total = 0;
  int bad   = 0;

  md5 dut (
    .clk            (clk),
    .reset          (reset),
    .data_in_ready  (data_in_ready),
    .data_in_length (data_in_length),
    .data_in        (data_in),
    .hash           (hash),
    .hash_ready     (hash_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] str_block(input string s);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[511 - 8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [31:0] le(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] md5_model(input logic [511:0] din, input int unsigned len);
    logic [7:0]  bt [64];
    logic [31:0] w [16];
    logic [63:0] bits;
    logic [31:0] a, b, c, d, f, t, kk;
    int unsigned n, g, s;
    real r;
    int unsigned sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    n = len / 8;
    if (n > 55) n = 55;
    for (int unsigned k = 0; k < 64; k++) bt[k] = (k < n) ? din[511 - 8*k -: 8] : 8'h00;
    bt[n] = 8'h80;
    bits = 64'(n) * 64'd8;
    for (int unsigned j = 0; j < 8; j++) bt[56 + j] = bits[8*j +: 8];
    for (int unsigned i = 0; i < 16; i++) w[i] = {bt[4*i+3], bt[4*i+2], bt[4*i+1], bt[4*i]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int unsigned i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i;                end
        1: begin f = (b & d) | (c & ~d); g = (5*i + 1) % 16;   end
        2: begin f = b ^ c ^ d;          g = (3*i + 5) % 16;   end
        default: begin f = c ^ (b | ~d); g = (7*i) % 16;       end
      endcase
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kk = 32'(longint'($floor(r * 4294967296.0)));
      s = sh[i/16][i%4];
      t = a + f + kk + w[g];
      t = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + t;
    end
    a += 32'h67452301; b += 32'hefcdab89; c += 32'h98badcfe; d += 32'h10325476;
    return {le(a), le(b), le(c), le(d)};
  endfunction

  // Accept on one edge, scramble inputs, then count edges until hash_ready (bounded).
  task automatic start_and_wait(input logic [511:0] din, input logic [8:0] len, output int unsigned lat);
    @(negedge clk);
    data_in        = din;
    data_in_length = len;
    data_in_ready  = 1'b1;
    @(posedge clk); #1;
    data_in        = rand512();
    data_in_length = 9'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (hash_ready === 1'b1) break;
    end
  endtask

  task automatic run_vec(input string tag, input logic [511:0] din, input logic [8:0] len,
                         input logic [127:0] exp);
    int unsigned lat;
    logic [127:0] h;
    logic stuck;
    start_and_wait(din, len, lat);
    chk({tag, " latency"}, 128'(lat), 128'd65);
    chk({tag, " digest"}, hash, exp);
    h = hash;
    stuck = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (hash_ready !== 1'b1 || hash !== h) stuck = 1'b1;
    end
    chk({tag, " hold"}, 128'(stuck), 128'd0);
    @(negedge clk);
    data_in_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready drop"}, 128'(hash_ready), 128'd0);
    chk({tag, " retained"}, hash, h);
  endtask

  initial begin
    logic [511:0] din;
    int unsigned  len;
    logic         early;

    reset = 1'b1; data_in_ready = 1'b0; data_in_length = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hash", hash, 128'd0);
    chk("reset ready", 128'(hash_ready), 128'd0);
    @(negedge clk);
    reset = 1'b0;

    run_vec("empty", '0, 9'd0, 128'hd41d8cd98f00b204e9800998ecf8427e);
    run_vec("abc", {24'h616263, 488'd0}, 9'd24, 128'h900150983cd24fb0d6963f7d28e17f72);
    din = rand512();
    din[511:504] = 8'h61;
    run_vec("a masked", din, 9'd8, 128'h0cc175b9c0f1b6a831c399e269772661);
    run_vec("fox", str_block("The quick brown fox jumps over the lazy dog"), 9'd344,
            128'h9e107d9d372bb6826bd81d3542a419d6);

    // Abort after step 30, then restart with "abc".
    @(negedge clk);
    data_in = {24'h616263, 488'd0}; data_in_length = 9'd24; data_in_ready = 1'b1;
    @(posedge clk); #1;
    early = 1'b0;
    repeat (31) begin
      @(posedge clk); #1;
      if (hash_ready !== 1'b0) early = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1; data_in_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort no ready", 128'(early | hash_ready), 128'd0);
    chk("abort hash", hash, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec("abc restart", {24'h616263, 488'd0}, 9'd24, 128'h900150983cd24fb0d6963f7d28e17f72);

    din = rand512();
    run_vec("len 440", din, 9'd440, md5_model(din, 440));
    din = rand512();
    run_vec("len 511", din, 9'd511, md5_model(din, 511));
    din = rand512();
    run_vec("len 13", din, 9'd13, md5_model(din, 13));

    for (int i = 0; i < 8; i++) begin
      din = rand512();
      len = $urandom_range(0, 511);
      run_vec($sformatf("rand%0d len=%0d", i, len), din, 9'(len), md5_model(din, len));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
